// File: rtl/circular_rotate_iterative.sv
// Iterative circular rotator: rotates a word by up to STEP bits per clock
// behind valid/ready handshakes on the request and result sides.
`timescale 1ns/1ps
module circular_rotate_iterative #(
  parameter int N = 8,
  parameter int STEP = 1,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amount,
  input  logic          in_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DONE
  } state_t;

  state_t          state;
  logic [N-1:0]    word;
  logic [AW-1:0]   rem;
  logic            dir;
  logic [AW-1:0]   eff;
  logic [AW-1:0]   k;
  logic [N-1:0]    rot_word;
  logic [2*N-1:0]  dbl;
  logic            take;

  assign in_ready = (state == IDLE) ||
                    ((state == DONE) && out_ready);
  assign take     = in_valid && in_ready;
  assign out_data = word;

  // Amounts at or above N wrap; only possible when N is not a power of 2
  if ((1 << AW) == N) begin : g_pow2
    assign eff = in_amount;
  end else begin : g_wrap
    localparam logic [AW-1:0] NA = AW'(N);
    assign eff = (in_amount >= NA) ? in_amount - NA
                                   : in_amount;
  end

  // Distance applied this cycle: the remainder, capped at STEP
  always_comb begin
    k = rem;
    if (int'(rem) > STEP) k = AW'(STEP);
  end

  // Rotate the held word by k using a doubled copy
  always_comb begin
    dbl = {word, word};
    rot_word = '0;
    if (dir) begin
      dbl = dbl >> k;
      rot_word = dbl[N-1:0];
    end else begin
      dbl = dbl << k;
      rot_word = dbl[2*N-1:N];
    end
  end

  // Control FSM with registered out_valid/busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word      <= '0;
      rem       <= '0;
      dir       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (take) begin
            word <= in_data;
            rem  <= eff;
            dir  <= in_dir;
            busy <= 1'b1;
            if (eff == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state     <= ROT;
              out_valid <= 1'b0;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        ROT: begin
          word <= rot_word;
          rem  <= rem - k;
          if (rem == k) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circular_rotate_iterative.sv
// Bench for circular_rotate_iterative: three configurations checked
// against a bit-index rotation model and a latency formula.
`timescale 1ns/1ps
module tb_circular_rotate_iterative;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] iv;
  logic [2:0] orr;
  logic [7:0] in_data;
  logic [2:0] in_amount;
  logic       in_dir;
  wire  [2:0] ir;
  wire  [2:0] ov;
  wire  [2:0] bz;
  wire  [7:0] od0;
  wire  [7:0] od1;
  wire  [5:0] od2;

  int cmp = 0;
  int err = 0;

  always #5 clk = ~clk;

  circular_rotate_iterative #(.N(8), .STEP(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(in_data), .in_amount(in_amount),
    .in_dir(in_dir),
    .out_valid(ov[0]), .out_ready(orr[0]),
    .out_data(od0), .busy(bz[0])
  );

  circular_rotate_iterative #(.N(8), .STEP(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(in_data), .in_amount(in_amount),
    .in_dir(in_dir),
    .out_valid(ov[1]), .out_ready(orr[1]),
    .out_data(od1), .busy(bz[1])
  );

  circular_rotate_iterative #(.N(6), .STEP(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(in_data[5:0]), .in_amount(in_amount),
    .in_dir(in_dir),
    .out_valid(ov[2]), .out_ready(orr[2]),
    .out_data(od2), .busy(bz[2])
  );

  function automatic int nn(input int s);
    return (s == 2) ? 6 : 8;
  endfunction

  function automatic int st(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 3 : 2);
  endfunction

  function automatic logic [7:0] get_od(input int s);
    if (s == 0) return od0;
    if (s == 1) return od1;
    return {2'b00, od2};
  endfunction

  function automatic logic [7:0] rot_ref(
    input int s, input logic [7:0] d,
    input int a, input bit dr);
    int n;
    int e;
    logic [7:0] r;
    n = nn(s);
    e = a % n;
    r = '0;
    for (int i = 0; i < n; i++)
      r[i] = dr ? d[(i + e) % n] : d[(i - e + n) % n];
    return r;
  endfunction

  function automatic int lat_ref(input int s, input int a);
    int e;
    e = a % nn(s);
    return 1 + (e + st(s) - 1) / st(s);
  endfunction

  task automatic accept(input int s, input logic [7:0] d,
                        input int a, input bit dr);
    @(negedge clk);
    in_data   = d;
    in_amount = 3'(a);
    in_dir    = dr;
    orr[s]    = 1'b0;
    iv[s]     = 1'b1;
    #1;
    cmp++;
    if (ir[s] !== 1'b1) begin
      err++;
      $display("FAIL accept_ready s=%0d got=%b want=1", s, ir[s]);
    end
    @(posedge clk);
    #1;
    iv[s] = 1'b0;
  endtask

  task automatic wait_result(input int s, input logic [7:0] exp,
                             input int explat);
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      iv[s]     = 1'($urandom % 2);
      in_data   = 8'($urandom);
      in_amount = 3'($urandom);
      in_dir    = 1'($urandom);
      cmp++;
      if (ir[s] !== 1'b0) begin
        err++;
        $display("FAIL busy_ready s=%0d got=%b want=0", s, ir[s]);
      end
      if (ov[s] === 1'b1) begin
        lat = c;
        seen = 1'b1;
        break;
      end
    end
    cmp++;
    if (!seen) begin
      err++;
      $display("FAIL timeout s=%0d got=none want=lat%0d", s, explat);
    end else if (lat != explat) begin
      err++;
      $display("FAIL latency s=%0d got=%0d want=%0d", s, lat, explat);
    end
    cmp++;
    if (seen && get_od(s) !== exp) begin
      err++;
      $display("FAIL data s=%0d got=%h want=%h", s, get_od(s), exp);
    end
    cmp++;
    if (bz[s] !== 1'b1) begin
      err++;
      $display("FAIL busy_done s=%0d got=%b want=1", s, bz[s]);
    end
  endtask

  task automatic hold(input int s, input int h, input logic [7:0] exp);
    for (int c = 0; c < h; c++) begin
      @(negedge clk);
      iv[s]     = 1'($urandom % 2);
      in_data   = 8'($urandom);
      in_dir    = 1'($urandom);
      cmp++;
      if (ov[s] !== 1'b1 || get_od(s) !== exp || ir[s] !== 1'b0) begin
        err++;
        $display("FAIL hold s=%0d got=v%b d%h r%b want=v1 d%h r0",
                 s, ov[s], get_od(s), ir[s], exp);
      end
    end
  endtask

  task automatic drain(input int s);
    orr[s] = 1'b1;
    iv[s]  = 1'b0;
    #1;
    cmp++;
    if (ir[s] !== 1'b1) begin
      err++;
      $display("FAIL drain_ready s=%0d got=%b want=1", s, ir[s]);
    end
    @(posedge clk);
    #1;
    orr[s] = 1'b0;
    cmp++;
    if (ov[s] !== 1'b0 || bz[s] !== 1'b0) begin
      err++;
      $display("FAIL drain_idle s=%0d got=v%b b%b want=v0 b0",
               s, ov[s], bz[s]);
    end
  endtask

  task automatic b2b(input int s, input logic [7:0] d,
                     input int a, input bit dr);
    orr[s]    = 1'b1;
    in_data   = d;
    in_amount = 3'(a);
    in_dir    = dr;
    iv[s]     = 1'b1;
    #1;
    cmp++;
    if (ir[s] !== 1'b1) begin
      err++;
      $display("FAIL b2b_ready s=%0d got=%b want=1", s, ir[s]);
    end
    @(posedge clk);
    #1;
    orr[s] = 1'b0;
    iv[s]  = 1'b0;
    cmp++;
    if (bz[s] !== 1'b1 || ov[s] !== ((a % nn(s)) == 0)) begin
      err++;
      $display("FAIL b2b_load s=%0d got=v%b b%b want=v%0d b1",
               s, ov[s], bz[s], int'((a % nn(s)) == 0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = '0;
    orr = '0;
    in_data = '0;
    in_amount = '0;
    in_dir = 1'b0;
    #12;
    cmp++;
    if (ov !== 3'b000 || bz !== 3'b000) begin
      err++;
      $display("FAIL reset_out got=v%b b%b want=v000 b000", ov, bz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp++;
    if (ir !== 3'b111) begin
      err++;
      $display("FAIL reset_ready got=%b want=111", ir);
    end
  endtask

  task automatic test_directed();
    accept(0, 8'hB1, 3, 1'b1);
    wait_result(0, 8'h36, 4);
    drain(0);
    accept(0, 8'hB1, 3, 1'b0);
    wait_result(0, 8'h8D, 4);
    drain(0);
    accept(0, 8'hB1, 0, 1'b0);
    wait_result(0, 8'hB1, 1);
    drain(0);
    accept(1, 8'h01, 7, 1'b0);
    wait_result(1, 8'h80, 4);
    drain(1);
    accept(2, 8'h01, 7, 1'b1);
    wait_result(2, 8'h20, 2);
    drain(2);
  endtask

  task automatic test_back_to_back();
    accept(0, 8'h5A, 2, 1'b1);
    wait_result(0, rot_ref(0, 8'h5A, 2, 1'b1), lat_ref(0, 2));
    hold(0, 5, rot_ref(0, 8'h5A, 2, 1'b1));
    b2b(0, 8'h96, 4, 1'b0);
    wait_result(0, rot_ref(0, 8'h96, 4, 1'b0), lat_ref(0, 4));
    drain(0);
  endtask

  task automatic test_reset_mid_rot();
    accept(0, 8'hC3, 5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    cmp++;
    if (bz[0] !== 1'b1 || ov[0] !== 1'b0) begin
      err++;
      $display("FAIL mid_rot got=v%b b%b want=v0 b1", ov[0], bz[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    cmp++;
    if (ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
      err++;
      $display("FAIL async_rst got=v%b b%b want=v0 b0", ov[0], bz[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cmp++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
        err++;
        $display("FAIL abandoned got=v%b r%b want=v0 r1", ov[0], ir[0]);
      end
    end
    accept(0, 8'hC3, 5, 1'b0);
    wait_result(0, rot_ref(0, 8'hC3, 5, 1'b0), lat_ref(0, 5));
    drain(0);
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] exp;
    int a;
    bit dr;
    for (int s = 0; s < 3; s++) begin
      d = 8'($urandom);
      a = int'($urandom % 8);
      dr = 1'($urandom);
      exp = rot_ref(s, d, a, dr);
      accept(s, d, a, dr);
      wait_result(s, exp, lat_ref(s, a));
      for (int t = 0; t < 20; t++) begin
        hold(s, int'($urandom % 3), exp);
        d = 8'($urandom);
        a = int'($urandom % 8);
        dr = 1'($urandom);
        exp = rot_ref(s, d, a, dr);
        if ($urandom % 2 == 0) begin
          b2b(s, d, a, dr);
        end else begin
          drain(s);
          accept(s, d, a, dr);
        end
        wait_result(s, exp, lat_ref(s, a));
      end
      drain(s);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_rot();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/circular_rotate_iterative.md
CIRCULAR_ROTATE_ITERATIVE -- requirements
Module: circular_rotate_iterative

Interface
REQ-001 Parameter N, default 8: data width in bits; SHALL be >= 2.
REQ-002 Parameter STEP, default 1: maximum rotate distance applied per clock; SHALL satisfy 1 <= STEP <= N.
REQ-003 Derived width AW = $clog2(N): width of the amount field.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  request present on in_data/in_amount/in_dir.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 in_data  input  N  word to rotate.
REQ-009 in_amount  input  AW  requested rotate distance in bits.
REQ-010 in_dir  input  1  0 = rotate left (toward MSB), 1 = rotate right (toward LSB).
REQ-011 out_valid  output  1  out_data holds a completed result.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 out_data  output  N  rotated word.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 Request accepted on rising edge with in_valid && in_ready; result accepted on rising edge with out_valid && out_ready.
REQ-016 Effective distance E = in_amount mod N, latched at acceptance; amounts >= N (possible when N is not a power of 2) SHALL wrap.
REQ-017 FSM states: IDLE, ROT, DONE; encoding free.
REQ-018 IDLE: in_ready=1, out_valid=0; on acceptance latch data, E, dir; go to ROT if E>0, else DONE.
REQ-019 ROT: each cycle rotate held word by K=min(remaining,STEP) in latched dir and decrement remaining by K; go to DONE on the cycle remaining reaches 0.
REQ-020 ROT: in_ready=0, out_valid=0; inputs ignored.
REQ-021 DONE: out_valid=1, out_data = held word, stable while out_ready=0 (backpressure holds indefinitely).
REQ-022 DONE with out_ready=1: in_ready=1; simultaneous new acceptance SHALL load the new request (to ROT or DONE per REQ-018) in the same edge, else go to IDLE.
REQ-023 Latency from acceptance edge to first out_valid cycle SHALL be exactly 1 + ceil(E/STEP) cycles; E=0 gives 1.
REQ-024 Rotation is lossless: every bit of in_data appears exactly once in out_data; left by E: out[i]=in[(i-E) mod N]; right by E: out[i]=in[(i+E) mod N].
REQ-025 Direction latched at acceptance; in_dir changes after acceptance SHALL have no effect.
REQ-026 in_ready SHALL depend only on state and out_ready (no combinational path from in_valid).
REQ-027 out_data outside DONE is don't-care; bench SHALL check it only when out_valid=1.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) force state IDLE, out_valid=0, busy=0, held word=0, remaining=0.
REQ-029 in_ready SHALL be 1 from the first cycle rst_n is high.
REQ-030 Reset mid-ROT or mid-DONE SHALL abandon the request with no result delivered.

Verification
REQ-031 N=8, STEP=1: in_data=0xB1, amount=3, dir=1 -> out_data=0x36, out_valid 4 cycles after acceptance.
REQ-032 N=8, STEP=1: in_data=0xB1, amount=3, dir=0 -> out_data=0x8D; amount=0 -> 0xB1 after 1 cycle.
REQ-033 N=8, STEP=3: in_data=0x01, amount=7, dir=0 -> out_data=0x80 after 4 cycles (3 ROT steps).
REQ-034 N=6, STEP=2: in_data=6'b000001, amount=7 (E=1), dir=1 -> out_data=6'b100000 after 2 cycles.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, out_data constant, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back acceptance, no bubble.
REQ-036 Drive rst_n low mid-ROT (N=8, STEP=1, amount=5) -> out_valid=0 and busy=0 without a clock edge; next request completes correctly.
